// File: rtl/adjust_pkg.sv
// rtl/adjust_pkg.sv - shared types, constants and saturating step helper for adjust_sequencer
package adjust_pkg;

    // FSM states of the adjustment sequencer
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        STEP     = 3'd1,
        HOLD     = 3'd2,
        REPEAT   = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // One +1/-1 step that holds the value when it would leave [min_v, max_v].
    // The caller detects saturation as "result equals input".
    function automatic int sat_step(input int value, input logic dir,
                                    input int min_v, input int max_v);
        int r;
        r = value;
        if (dir == DIR_UP) begin
            if (value < max_v) r = value + 1;
        end else begin
            if (value > min_v) r = value - 1;
        end
        return r;
    endfunction

    // Width needed to hold max(a,b)-1; never below one bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/repeat_timer.sv
// rtl/repeat_timer.sv - loadable down-counter with zero flag for button auto-repeat
//  clk, rst_n : clock, asynchronous active-low reset
//  load       : load strobe, takes priority over dec
//  load_val   : value loaded on load
//  dec        : decrement by one (stops at zero)
//  zero       : counter currently at zero
module repeat_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/adjust_sequencer.sv
// rtl/adjust_sequencer.sv - frequency/current setpoint adjustment with press, hold and auto-repeat
//  clk, rst_n : clock, asynchronous active-low reset
//  sel        : 1 = adjust frequency, 0 = adjust current
//  btn_up/dn  : debounced increment / decrement request levels
//  frec_en    : registered sel; cor_en : registered ~sel
//  frec_val   : frequency setpoint; cor_val : current setpoint
//  upd        : one-cycle pulse when a setpoint changed
//  sat        : one-cycle pulse when a step was blocked by a limit
module adjust_sequencer
    import adjust_pkg::*;
#(
    parameter int FW       = 4,
    parameter int CW       = 4,
    parameter int F_INIT   = 1,
    parameter int C_INIT   = 0,
    parameter int F_MIN    = 1,
    parameter int F_MAX    = 15,
    parameter int C_MIN    = 0,
    parameter int C_MAX    = 15,
    parameter int HOLD_CYC = 50_000_000,
    parameter int RPT_CYC  = 10_000_000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sel,
    input  logic          btn_up,
    input  logic          btn_dn,
    output logic          frec_en,
    output logic          cor_en,
    output logic [FW-1:0] frec_val,
    output logic [CW-1:0] cor_val,
    output logic          upd,
    output logic          sat
);

    localparam int TW = timer_width(HOLD_CYC, RPT_CYC);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] RPT_LD  = TW'(RPT_CYC - 1);

    state_t        state;
    logic          dir;      // latched step direction
    logic          tgt;      // latched sel: 1 = frequency is the target
    logic          held;     // latched-direction button still pressed
    logic          abort;
    logic          fire;     // a step is attempted this cycle
    logic          tmr_load;
    logic          tmr_dec;
    logic [TW-1:0] tmr_val;
    logic          tmr_zero;
    logic [FW-1:0] f_next;
    logic [CW-1:0] c_next;
    logic          hit_lim;

    repeat_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // The opposite button alone does not keep a hold alive; both buttons
    // together, or a change of target, abandon the hold without a step.
    always_comb begin
        held     = (dir == DIR_UP) ? btn_up : btn_dn;
        abort    = (sel != tgt) || (btn_up && btn_dn);
        fire     = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        tmr_val  = HOLD_LD;
        case (state)
            STEP: begin
                fire     = 1'b1;
                tmr_load = 1'b1;
                tmr_val  = HOLD_LD;
            end
            HOLD, REPEAT: begin
                if (!abort && held) begin
                    if (tmr_zero) begin
                        fire     = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = RPT_LD;
                    end else begin
                        tmr_dec = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        f_next  = FW'(sat_step(int'(frec_val), dir, F_MIN, F_MAX));
        c_next  = CW'(sat_step(int'(cor_val), dir, C_MIN, C_MAX));
        // A legal step always changes the value, so "unchanged" means blocked.
        hit_lim = tgt ? (f_next == frec_val) : (c_next == cor_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir      <= DIR_UP;
            tgt      <= 1'b0;
            frec_en  <= 1'b0;
            cor_en   <= 1'b1;
            frec_val <= FW'(F_INIT);
            cor_val  <= CW'(C_INIT);
            upd      <= 1'b0;
            sat      <= 1'b0;
        end else begin
            frec_en <= sel;
            cor_en  <= ~sel;
            upd     <= 1'b0;
            sat     <= 1'b0;

            if (fire) begin
                if (hit_lim) begin
                    sat <= 1'b1;
                end else begin
                    upd <= 1'b1;
                    if (tgt) frec_val <= f_next;
                    else     cor_val  <= c_next;
                end
            end

            case (state)
                IDLE: begin
                    if (btn_up && btn_dn) begin
                        state <= WAIT_REL;
                    end else if (btn_up || btn_dn) begin
                        state <= STEP;
                        dir   <= btn_up ? DIR_UP : DIR_DN;
                        tgt   <= sel;
                    end
                end
                STEP: state <= HOLD;
                HOLD, REPEAT: begin
                    if (abort)         state <= WAIT_REL;
                    else if (!held)    state <= IDLE;
                    else if (tmr_zero) state <= REPEAT;
                end
                WAIT_REL: begin
                    if (!btn_up && !btn_dn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
